// File: rtl/nibble_arb_pkg.sv
// Shared definitions for the nibble register arbiter: FSM state encoding,
// default parameter values and a parity helper used by the optional
// byteout parity output.
package nibble_arb_pkg;

    localparam int NREQ_DEF     = 4;
    localparam int WIDTH_DEF    = 4;
    localparam int MAX_HOLD_DEF = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

    // XOR of all bits; callers zero-extend narrower data into the 32-bit argument.
    function automatic logic xor_reduce(input logic [31:0] value);
        return ^value;
    endfunction

endpackage

// File: rtl/nibble_reg_arbiter_rr_pick.sv
// Combinational round-robin winner search. The requester closest above
// last_winner (with wrap from NREQ-1 to 0) wins; any_req flags that at
// least one request bit is set.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] last_winner,
    output logic [IDXW-1:0] winner,
    output logic            any_req
);

    int best_s;
    int dist_s;

    // Pick the requester with the smallest rotational distance past last_winner.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        best_s  = NREQ;
        dist_s  = 0;
        for (int i = 0; i < NREQ; i++) begin
            dist_s = (i - int'(last_winner) - 1 + 2 * NREQ) % NREQ;
            if (req[i] && (dist_s < best_s)) begin
                best_s  = dist_s;
                winner  = IDXW'(i);
                any_req = 1'b1;
            end else begin
                best_s = best_s;
            end
        end
    end

endmodule

// File: rtl/nibble_reg_arbiter.sv
// Round-robin arbiter granting one requester at a time access to a shared
// registered data output. A grant lasts until the owner drops its request or
// MAX_HOLD captures have been made, followed by one RELEASE cycle.
// Optional feature: define NIBBLE_ARB_PARITY_EN to add the registered
// byteout_par output (XOR of the byteout bits).
module nibble_reg_arbiter
    import nibble_arb_pkg::*;
#(
    parameter int NREQ     = NREQ_DEF,
    parameter int WIDTH    = WIDTH_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic                  clockfa,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] byteIn,
    output logic [NREQ-1:0]       gnt,
    output logic [WIDTH-1:0]      byteout,
    output logic                  valid,
    output logic                  busy
`ifdef NIBBLE_ARB_PARITY_EN
    ,
    output logic                  byteout_par
`endif
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int HW   = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] MAX_HOLD_C = HW'(MAX_HOLD);

    arb_state_e        state_r;
    logic [NREQ-1:0]   gnt_r;
    logic [WIDTH-1:0]  byteout_r;
    logic              valid_r;
    logic              busy_r;
    logic [HW-1:0]     hold_r;
    logic [IDXW-1:0]   last_r;

    logic [IDXW-1:0]   winner_s;
    logic              any_req_s;
    logic [NREQ-1:0]   onehot_s;
    logic              sel_req_s;
    logic [WIDTH-1:0]  sel_data_s;
    logic              capture_s;
    logic              last_capture_s;

    rr_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_rr_pick (
        .req         (req),
        .last_winner (last_r),
        .winner      (winner_s),
        .any_req     (any_req_s)
    );

    // Route the current owner's request bit and data slice (last_r is the owner in GRANT).
    always_comb begin
        sel_req_s  = 1'b0;
        sel_data_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (last_r == IDXW'(i)) begin
                sel_req_s  = req[i];
                sel_data_s = byteIn[i*WIDTH +: WIDTH];
            end else begin
                sel_req_s  = sel_req_s;
            end
        end
    end

    // Decode the round-robin winner into a one-hot grant vector.
    always_comb begin
        onehot_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            onehot_s[i] = (winner_s == IDXW'(i));
        end
    end

    assign capture_s      = (state_r == GRANT) && sel_req_s;
    assign last_capture_s = (hold_r == (MAX_HOLD_C - HW'(1)));

    // Arbitration FSM with hold counter and shared data register.
    always_ff @(posedge clockfa or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            gnt_r     <= '0;
            byteout_r <= '0;
            valid_r   <= 1'b0;
            busy_r    <= 1'b0;
            hold_r    <= '0;
            last_r    <= IDXW'(NREQ - 1);
        end else begin
            case (state_r)
                IDLE: begin
                    valid_r <= 1'b0;
                    if (any_req_s) begin
                        gnt_r   <= onehot_s;
                        last_r  <= winner_s;
                        hold_r  <= '0;
                        busy_r  <= 1'b1;
                        state_r <= GRANT;
                    end else begin
                        gnt_r   <= '0;
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                GRANT: begin
                    if (capture_s) begin
                        byteout_r <= sel_data_s;
                        valid_r   <= 1'b1;
                        if (last_capture_s) begin
                            // Counter parks at MAX_HOLD rather than wrapping.
                            hold_r  <= MAX_HOLD_C;
                            gnt_r   <= '0;
                            state_r <= RELEASE;
                        end else begin
                            hold_r  <= hold_r + HW'(1);
                            state_r <= GRANT;
                        end
                    end else begin
                        valid_r <= 1'b0;
                        gnt_r   <= '0;
                        state_r <= RELEASE;
                    end
                end
                RELEASE: begin
                    valid_r <= 1'b0;
                    gnt_r   <= '0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    valid_r <= 1'b0;
                    gnt_r   <= '0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

`ifdef NIBBLE_ARB_PARITY_EN
    logic par_r;

    // Parity of the captured data, updated in lockstep with byteout.
    always_ff @(posedge clockfa or negedge rst_n) begin
        if (!rst_n) begin
            par_r <= 1'b0;
        end else if (capture_s) begin
            par_r <= xor_reduce(32'(sel_data_s));
        end else begin
            par_r <= par_r;
        end
    end

    assign byteout_par = par_r;
`endif

    assign gnt     = gnt_r;
    assign byteout = byteout_r;
    assign valid   = valid_r;
    assign busy    = busy_r;

endmodule
